// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: decodes ARMv4 data-processing fields into the ALUControl
// select, holds it for the operation's latency and strobes res_valid when the
// multiplexer output is the finished result. Multi-cycle MULT/DIV ops stall
// new requests through in_ready until their final cycle.
module alu_op_sequencer #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] cmd,
  input  logic [1:0] sh,
  input  logic       is_mul,
  input  logic       is_div,
  input  logic       flush,
  output logic [3:0] ALUControl,
  output logic       op_active,
  output logic       res_valid,
  output logic       illegal
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CTRL_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic              illegal_d;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic [CNT_W-1:0]  dec_lat;
  logic              last_cycle;
  logic              accept;

  // Decode request fields: divide beats multiply beats the opcode map
  always_comb begin
    dec_ctrl    = 4'b0000;
    dec_illegal = 1'b0;
    dec_lat     = CNT_W'(1);
    if (is_div) begin
      dec_ctrl = 4'b0011;
      dec_lat  = CNT_W'(DIV_CYCLES);
    end else if (is_mul) begin
      dec_ctrl = 4'b0010;
      dec_lat  = CNT_W'(MUL_CYCLES);
    end else begin
      unique case (cmd)
        4'b0100: dec_ctrl = 4'b0000;
        4'b0010: dec_ctrl = 4'b0001;
        4'b1010: dec_ctrl = 4'b0001;
        4'b0000: dec_ctrl = 4'b0110;
        4'b1100: dec_ctrl = 4'b0111;
        4'b0001: dec_ctrl = 4'b1000;
        4'b1111: dec_ctrl = 4'b1001;
        4'b1101: begin
          unique case (sh)
            2'b00:   dec_ctrl = 4'b0100;
            2'b01:   dec_ctrl = 4'b0101;
            default: dec_illegal = 1'b1;
          endcase
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // Handshake and status outputs, gated by reset and flush (no path from inputs other than those)
  always_comb begin
    last_cycle = (state_q == EXEC) && (cnt_q == CNT_W'(1));
    op_active  = (state_q == EXEC) && !reset && !flush;
    res_valid  = op_active && last_cycle;
    in_ready   = !reset && !flush && ((state_q == IDLE) || last_cycle);
    accept     = in_valid && in_ready;
  end

  // Next state: flush aborts, accept reloads, otherwise count down to IDLE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ALUControl;
    illegal_d = illegal;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      state_d   = EXEC;
      cnt_d     = dec_lat;
      ctrl_d    = dec_ctrl;
      illegal_d = dec_illegal;
    end else if (state_q == EXEC) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (last_cycle) state_d = IDLE;
    end
  end

  // State, counter and held select registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ALUControl <= '0;
      illegal    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ALUControl <= ctrl_d;
      illegal    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cmd;
  logic [1:0] sh;
  logic       is_mul;
  logic       is_div;
  logic       flush;
  logic [3:0] ALUControl;
  logic       op_active;
  logic       res_valid;
  logic       illegal;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.MUL_CYCLES(2), .DIV_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cmd        (cmd),
    .sh         (sh),
    .is_mul     (is_mul),
    .is_div     (is_div),
    .flush      (flush),
    .ALUControl (ALUControl),
    .op_active  (op_active),
    .res_valid  (res_valid),
    .illegal    (illegal)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vecs++;
    if ({ALUControl, illegal, op_active, res_valid, in_ready} !== 8'b0000_0000) begin
      errs++;
      $display("FAIL reset_state: got ctrl=%b ill=%b act=%b rv=%b rdy=%b, want 0000 0 0 0 0",
               ALUControl, illegal, op_active, res_valid, in_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vecs++;
    if (in_ready !== 1'b1 || op_active !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: got rdy=%b act=%b, want rdy=1 act=0", in_ready, op_active);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] c [4] = '{4'b0100, 4'b0010, 4'b1100, 4'b1101};
    logic [1:0] s [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
    logic [3:0] e [4] = '{4'b0000, 4'b0001, 4'b0111, 4'b0101};
    @(posedge clk);
    #1 in_valid = 1'b1; cmd = c[0]; sh = s[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) begin cmd = c[i+1]; sh = s[i+1]; end
      else in_valid = 1'b0;
      @(negedge clk);
      vecs++;
      if (ALUControl !== e[i] || op_active !== 1'b1 || res_valid !== 1'b1 || illegal !== 1'b0) begin
        errs++;
        $display("FAIL b2b_%0d: got ctrl=%b act=%b rv=%b ill=%b, want %b 1 1 0",
                 i, ALUControl, op_active, res_valid, illegal, e[i]);
      end
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vecs++;
    if (op_active !== 1'b0 || res_valid !== 1'b0 || ALUControl !== 4'b0101) begin
      errs++;
      $display("FAIL b2b_idle: got act=%b rv=%b ctrl=%b, want 0 0 0101", op_active, res_valid, ALUControl);
    end
  endtask

  task automatic test_decode_table();
    logic [3:0] c [7] = '{4'b1010, 4'b0000, 4'b0001, 4'b1111, 4'b1101, 4'b1101, 4'b0011};
    logic [1:0] s [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
    logic [3:0] e [7] = '{4'b0001, 4'b0110, 4'b1000, 4'b1001, 4'b0100, 4'b0000, 4'b0000};
    logic       x [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    @(posedge clk);
    #1 in_valid = 1'b1; cmd = c[0]; sh = s[0];
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      if (i < 6) begin cmd = c[i+1]; sh = s[i+1]; end
      else in_valid = 1'b0;
      @(negedge clk);
      vecs++;
      if (ALUControl !== e[i] || illegal !== x[i] || res_valid !== 1'b1) begin
        errs++;
        $display("FAIL decode_%0d: got ctrl=%b ill=%b rv=%b, want %b %b 1",
                 i, ALUControl, illegal, res_valid, e[i], x[i]);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_div_latency();
    @(posedge clk);
    #1 in_valid = 1'b1; is_div = 1'b1;
    @(posedge clk);
    #1 is_div = 1'b0; cmd = 4'b0100; sh = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vecs++;
      if (ALUControl !== 4'b0011 || op_active !== 1'b1 || res_valid !== (k == 8) || in_ready !== (k == 8)) begin
        errs++;
        $display("FAIL div_cycle_%0d: got ctrl=%b act=%b rv=%b rdy=%b, want 0011 1 %b %b",
                 k, ALUControl, op_active, res_valid, in_ready, k == 8, k == 8);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (ALUControl !== 4'b0000 || op_active !== 1'b1 || res_valid !== 1'b1) begin
      errs++;
      $display("FAIL div_queued_add: got ctrl=%b act=%b rv=%b, want 0000 1 1", ALUControl, op_active, res_valid);
    end
    @(posedge clk);
  endtask

  task automatic test_priority_illegal();
    @(posedge clk);
    #1 in_valid = 1'b1; is_mul = 1'b1; is_div = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; is_mul = 1'b0; is_div = 1'b0;
    @(negedge clk);
    vecs++;
    if (ALUControl !== 4'b0011 || op_active !== 1'b1 || in_ready !== 1'b0) begin
      errs++;
      $display("FAIL prio_div: got ctrl=%b act=%b rdy=%b, want 0011 1 0", ALUControl, op_active, in_ready);
    end
    repeat (7) @(posedge clk);
    #1 in_valid = 1'b1; cmd = 4'b1101; sh = 2'b10;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (ALUControl !== 4'b0000 || illegal !== 1'b1 || res_valid !== 1'b1) begin
      errs++;
      $display("FAIL illegal_op: got ctrl=%b ill=%b rv=%b, want 0000 1 1", ALUControl, illegal, res_valid);
    end
    @(posedge clk);
    #1 in_valid = 1'b1; cmd = 4'b0000; sh = 2'b00;
    @(negedge clk);
    vecs++;
    if (res_valid !== 1'b0 || op_active !== 1'b0 || illegal !== 1'b1 || ALUControl !== 4'b0000) begin
      errs++;
      $display("FAIL illegal_once: got rv=%b act=%b ill=%b ctrl=%b, want 0 0 1 0000",
               res_valid, op_active, illegal, ALUControl);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (ALUControl !== 4'b0110 || illegal !== 1'b0) begin
      errs++;
      $display("FAIL illegal_clear: got ctrl=%b ill=%b, want 0110 0", ALUControl, illegal);
    end
    @(posedge clk);
  endtask

  task automatic test_mul_latency();
    @(posedge clk);
    #1 in_valid = 1'b1; is_mul = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; is_mul = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vecs++;
      if (ALUControl !== 4'b0010 || op_active !== (k <= 2) || res_valid !== (k == 2)) begin
        errs++;
        $display("FAIL mul_cycle_%0d: got ctrl=%b act=%b rv=%b, want 0010 %b %b",
                 k, ALUControl, op_active, res_valid, k <= 2, k == 2);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_flush();
    @(posedge clk);
    #1 in_valid = 1'b1; is_mul = 1'b1;
    @(posedge clk);
    #1 is_mul = 1'b0; cmd = 4'b1100; flush = 1'b1;
    @(negedge clk);
    vecs++;
    if (res_valid !== 1'b0 || op_active !== 1'b0 || in_ready !== 1'b0 || ALUControl !== 4'b0010) begin
      errs++;
      $display("FAIL flush_cycle: got rv=%b act=%b rdy=%b ctrl=%b, want 0 0 0 0010",
               res_valid, op_active, in_ready, ALUControl);
    end
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (in_ready !== 1'b1 || op_active !== 1'b0 || res_valid !== 1'b0 || ALUControl !== 4'b0010) begin
      errs++;
      $display("FAIL flush_idle: got rdy=%b act=%b rv=%b ctrl=%b, want 1 0 0 0010",
               in_ready, op_active, res_valid, ALUControl);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_div();
    @(posedge clk);
    #1 in_valid = 1'b1; is_div = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; is_div = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    vecs++;
    if (op_active !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b0) begin
      errs++;
      $display("FAIL rst_div_gate: got act=%b rv=%b rdy=%b, want 0 0 0", op_active, res_valid, in_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vecs++;
      if (ALUControl !== 4'b0000 || illegal !== 1'b0 || op_active !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b1) begin
        errs++;
        $display("FAIL rst_div_after_%0d: got ctrl=%b ill=%b act=%b rv=%b rdy=%b, want 0000 0 0 0 1",
                 k, ALUControl, illegal, op_active, res_valid, in_ready);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; cmd = 4'b0000; sh = 2'b00;
    is_mul = 1'b0; is_div = 1'b0; flush = 1'b0;
    test_reset();
    test_back_to_back();
    test_decode_table();
    test_div_latency();
    test_priority_illegal();
    test_mul_latency();
    test_flush();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Issue-side companion to the ALU result multiplexer. It decodes ARMv4 data-processing fields into the 4-bit ALUControl select consumed by that multiplexer, registers and holds the select for the operation's full latency, and emits a one-cycle result strobe when the selected result is valid. Single-cycle operations issue back-to-back; MULT and DIV occupy the ALU for a parameterised number of cycles under a valid/ready handshake.

## Interface

Parameters:
- MUL_CYCLES, 2: cycles ALUControl is held for a MULT (legal range 1..15)
- DIV_CYCLES, 8: cycles ALUControl is held for a DIV (legal range 1..15)

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request present on cmd/sh/is_mul/is_div
- in_ready  output  1  sequencer can accept a request this cycle
- cmd  input  4  ARM data-processing opcode field
- sh  input  2  shift-type field, used only when cmd = 1101 (MOV)
- is_mul  input  1  request is a multiply
- is_div  input  1  request is a divide
- flush  input  1  synchronous abort of the operation in flight
- ALUControl  output  4  registered select to the ALU result multiplexer
- op_active  output  1  ALUControl currently belongs to an operation in flight
- res_valid  output  1  one-cycle strobe: multiplexer output is the result of the current operation
- illegal  output  1  registered; current operation had an undecodable encoding

## Operation

- Decode priority: is_div, then is_mul, then cmd. is_div -> 0011 (DIV, latency DIV_CYCLES). is_mul -> 0010 (MULT, latency MUL_CYCLES). Both set -> DIV.
- cmd map, latency 1: 0100 ADD -> 0000; 0010 SUB -> 0001; 1010 CMP -> 0001; 0000 AND -> 0110; 1100 ORR -> 0111; 0001 EOR -> 1000; 1111 MVN -> 1001; 1101 MOV with sh=00 -> 0100 (SLL), sh=01 -> 0101 (SRL).
- MOV with sh=10/11, or any other cmd: ALUControl = 0000, illegal = 1, latency 1, res_valid still pulses. Legal decodes set illegal = 0.
- States: IDLE, EXEC. 4-bit down-counter cnt holds remaining cycles.
- IDLE: in_ready = 1. Accept (in_valid & in_ready) -> load ALUControl, illegal, cnt = latency; go EXEC.
- EXEC: op_active = 1; cnt decrements each cycle; res_valid = 1 when cnt = 1.
- In EXEC with cnt = 1: in_ready = 1. Accept -> reload as above, stay EXEC. No accept -> IDLE.
- In EXEC with cnt > 1: in_ready = 0; in_valid ignored.
- After completion, ALUControl and illegal hold their last values until the next accept.
- flush = 1 (state != reset): go IDLE, op_active = 0, res_valid = 0 that cycle, in_ready = 0 that cycle, no accept that cycle. ALUControl and illegal hold.

## Timing

- Reset (sampled high on an edge): state IDLE, cnt = 0, ALUControl = 0000, illegal = 0. While reset is high: op_active = 0, res_valid = 0, in_ready = 0. First accept is possible in the cycle after reset deasserts.
- Accept at edge E: ALUControl valid from E; op_active high for exactly L cycles, L = op latency; res_valid high in the L-th cycle only.
- op_active, res_valid and in_ready are combinational from state/cnt, gated by reset and flush. No combinational path from in_valid/cmd to any output.
- Throughput: latency-1 ops accept every cycle with op_active continuously high. Multi-cycle ops accept the next request in their final cycle: zero bubbles.
- reset has priority over flush; flush has priority over accept.
- Reset mid-EXEC: abort at once; no res_valid for the aborted op.

## Test plan

- Reset then IDLE: reset high 2 cycles -> ALUControl=0000, op_active=0, res_valid=0, in_ready=0; after release, in_ready=1.
- Back-to-back singles: cmd 0100, 0010, 1100, 1101/sh=01 on consecutive cycles, in_valid held -> ALUControl 0000, 0001, 0111, 0101 on consecutive cycles; res_valid and op_active high for all 4 cycles.
- DIV latency, DIV_CYCLES=8: accept is_div=1 -> ALUControl=0011, op_active high 8 cycles, res_valid only in the 8th, in_ready low in cycles 1-7. A queued ADD is accepted in cycle 8 and shows 0000 in cycle 9.
- Priority and illegal: is_mul=is_div=1 -> 0011. cmd=1101/sh=10 -> ALUControl=0000, illegal=1, res_valid pulses once. The next legal op clears illegal.
- Flush mid-MULT, MUL_CYCLES=2: flush in cycle 1 -> no res_valid, op_active low, in_ready low that cycle; IDLE next cycle with ALUControl still 0010.
- Reset mid-DIV at cycle 4 -> no res_valid; outputs take reset values.
